// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the 5-stage MIPS core. This package
//               holds the default datapath and register-index widths, the
//               ALU operation encodings and the hard-wired zero register
//               index.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Default widths. Module parameters named DW/RW pick these up.
    localparam int DW_DEFAULT = 32;
    localparam int RW_DEFAULT = 5;

    // ALU operation encodings carried on alu_op.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b011;

    // $zero always reads 0. A write that targets it must never be
    // forwarded and must never cause a stall.
    localparam int unsigned REG_ZERO = 0;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_if
// Description : Bundle between decode, the ID/EX stage and the later stages.
//               The stage uses the 'slave' modport: it receives decode
//               fields, flush and the MEM/WB writeback triples, and drives
//               stall and the EX-side operands/control. The 'master' modport
//               is the opposite view, for whatever drives the stage.
//   Parameters : DW - datapath width, RW - register index width
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_if
    import mips_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int RW = RW_DEFAULT
);
    // Decode slot
    logic          id_valid;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic [2:0]    id_alu_op;
    logic [3:0]    id_shamt;
    logic          id_alu_src;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          flush;

    // Writeback information from later stages
    logic          mem_reg_write;
    logic [RW-1:0] mem_rd;
    logic [DW-1:0] mem_result;
    logic          wb_reg_write;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_result;

    // Stage outputs
    logic          stall;
    logic          ex_valid;
    logic [DW-1:0] ex_alu_a;
    logic [DW-1:0] ex_alu_b;
    logic [2:0]    ex_alu_op;
    logic [3:0]    ex_shamt;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_shamt, id_alu_src, id_reg_write, id_mem_read,
               id_mem_write, flush,
               mem_reg_write, mem_rd, mem_result,
               wb_reg_write, wb_rd, wb_result,
        output stall, ex_valid, ex_alu_a, ex_alu_b, ex_alu_op, ex_shamt,
               ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_shamt, id_alu_src, id_reg_write, id_mem_read,
               id_mem_write, flush,
               mem_reg_write, mem_rd, mem_result,
               wb_reg_write, wb_rd, wb_result,
        input  stall, ex_valid, ex_alu_a, ex_alu_b, ex_alu_op, ex_shamt,
               ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );

endinterface : id_ex_if
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : forward_unit
// Description : Operand bypass select for one source register. It returns
//               the MEM-stage result when MEM is writing this source, else
//               the WB-stage result when WB is writing it, else the
//               registered register-file value. $zero is never bypassed.
//   Ports : i_src                          source register index
//           i_reg_data                     registered register-file data
//           i_mem_we / i_mem_rd / i_mem_data  EX/MEM writeback triple
//           i_wb_we  / i_wb_rd  / i_wb_data   MEM/WB writeback triple
//           o_data                         selected operand
// Revision    : 1.0 - initial release
// ============================================================================
module forward_unit
    import mips_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  wire logic [RW-1:0] i_src,
    input  wire logic [DW-1:0] i_reg_data,
    input  wire logic          i_mem_we,
    input  wire logic [RW-1:0] i_mem_rd,
    input  wire logic [DW-1:0] i_mem_data,
    input  wire logic          i_wb_we,
    input  wire logic [RW-1:0] i_wb_rd,
    input  wire logic [DW-1:0] i_wb_data,
    output logic      [DW-1:0] o_data
);

    logic w_src_nonzero;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_src_nonzero = (i_src != RW'(REG_ZERO));
    assign w_mem_hit     = i_mem_we && (i_mem_rd == i_src) && w_src_nonzero;
    assign w_wb_hit      = i_wb_we  && (i_wb_rd  == i_src) && w_src_nonzero;

    // MEM holds the younger write, so it wins over WB.
    always_comb begin
        o_data = i_reg_data;
        if (w_mem_hit) begin
            o_data = i_mem_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

endmodule : forward_unit
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register of the 5-stage MIPS core. It captures
//               decoded operands and control, resolves RAW hazards by
//               bypassing from the MEM and WB stages, and detects load-use
//               hazards. On a load-use hazard it stalls decode and inserts a
//               bubble into EX.
//   Ports : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - id_ex_if.slave: decode fields, flush, MEM/WB writeback
//                   triples in; stall and EX operands/control out
//   Config: ID_EX_FORWARD_EN - when defined, enables the bypass muxes and
//           the load-use stall. When undefined, operands come straight from
//           the pipeline register, stall is 0 and the mem_*/wb_* inputs are
//           ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst_n,
    id_ex_if.slave    bus
);

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    logic          r_ex_valid;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [DW-1:0] r_imm;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [RW-1:0] r_rd;
    logic [2:0]    r_alu_op;
    logic [3:0]    r_shamt;
    logic          r_alu_src;
    logic          r_reg_write;
    logic          r_mem_read;
    logic          r_mem_write;

    logic          w_stall;
    logic          w_load;
    logic          w_mem_we;
    logic          w_wb_we;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;

`ifdef ID_EX_FORWARD_EN
    logic w_hazard;

    assign w_mem_we = bus.mem_reg_write;
    assign w_wb_we  = bus.wb_reg_write;

    // The load in EX delivers its data only after MEM, so a dependent
    // instruction in ID must wait one cycle and then pick it up from WB.
    assign w_hazard = r_ex_valid && r_mem_read && (r_rd != RW'(REG_ZERO)) &&
                      bus.id_valid &&
                      ((r_rd == bus.id_rs) || (r_rd == bus.id_rt));

    // A taken branch kills the ID slot, so there is nothing left to hold.
    assign w_stall  = w_hazard && !bus.flush;
`else
    logic w_unused_wb_ctl;

    // With bypassing disabled the write enables are masked, so the
    // forward units always return the registered values.
    assign w_mem_we        = 1'b0;
    assign w_wb_we         = 1'b0;
    assign w_stall         = 1'b0;
    assign w_unused_wb_ctl = bus.mem_reg_write ^ bus.wb_reg_write;
`endif

    assign w_load = !bus.flush && !w_stall;

    // Bubbles clear everything (data fields too) so EX contents are
    // deterministic. An invalid ID slot loads with its side effects masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_alu_op    <= 3'b000;
            r_shamt     <= 4'd0;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (!w_load) begin
            r_ex_valid  <= 1'b0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_alu_op    <= 3'b000;
            r_shamt     <= 4'd0;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_ex_valid  <= bus.id_valid;
            r_rs_data   <= bus.id_rs_data;
            r_rt_data   <= bus.id_rt_data;
            r_imm       <= bus.id_imm;
            r_rs        <= bus.id_rs;
            r_rt        <= bus.id_rt;
            r_rd        <= bus.id_rd;
            r_alu_op    <= bus.id_alu_op;
            r_shamt     <= bus.id_shamt;
            r_alu_src   <= bus.id_alu_src;
            r_reg_write <= bus.id_reg_write && bus.id_valid;
            r_mem_read  <= bus.id_mem_read  && bus.id_valid;
            r_mem_write <= bus.id_mem_write && bus.id_valid;
        end
    end

    // ------------------------------------------------------------------
    // Operand bypass, applied after the pipeline register so that a
    // change on the MEM/WB inputs shows up on the operands in the same
    // cycle.
    // ------------------------------------------------------------------
    forward_unit #(
        .DW (DW),
        .RW (RW)
    ) u_fwd_rs (
        .i_src      (r_rs),
        .i_reg_data (r_rs_data),
        .i_mem_we   (w_mem_we),
        .i_mem_rd   (bus.mem_rd),
        .i_mem_data (bus.mem_result),
        .i_wb_we    (w_wb_we),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_data  (bus.wb_result),
        .o_data     (w_fwd_rs)
    );

    forward_unit #(
        .DW (DW),
        .RW (RW)
    ) u_fwd_rt (
        .i_src      (r_rt),
        .i_reg_data (r_rt_data),
        .i_mem_we   (w_mem_we),
        .i_mem_rd   (bus.mem_rd),
        .i_mem_data (bus.mem_result),
        .i_wb_we    (w_wb_we),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_data  (bus.wb_result),
        .o_data     (w_fwd_rt)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall         = w_stall;
    assign bus.ex_valid      = r_ex_valid;
    assign bus.ex_alu_a      = w_fwd_rs;
    assign bus.ex_alu_b      = r_alu_src ? r_imm : w_fwd_rt;
    // Stores always need the rt value, even when operand B is the offset.
    assign bus.ex_store_data = w_fwd_rt;
    assign bus.ex_alu_op     = r_alu_op;
    assign bus.ex_shamt      = r_shamt;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_reg_write  = r_reg_write;
    assign bus.ex_mem_read   = r_mem_read;
    assign bus.ex_mem_write  = r_mem_write;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. A table of directed
//               vectors covers loading, bypass selection, $zero handling,
//               immediate/store operands and invalid-slot masking; hand
//               sequences cover load-use stall, flush priority and reset
//               during a stall. A standalone forward_unit is also checked.
//               Expected values follow the ID_EX_FORWARD_EN build setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import mips_pkg::*;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    id_ex_if #(.DW(32), .RW(5)) bus ();

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Standalone bypass-select instance
    logic [4:0]  f_src, f_mrd, f_wrd;
    logic [31:0] f_reg, f_mdata, f_wdata, f_out;
    logic        f_mwe, f_wwe;

    forward_unit #(.DW(32), .RW(5)) u_fwd_chk (
        .i_src      (f_src),
        .i_reg_data (f_reg),
        .i_mem_we   (f_mwe),
        .i_mem_rd   (f_mrd),
        .i_mem_data (f_mdata),
        .i_wb_we    (f_wwe),
        .i_wb_rd    (f_wrd),
        .i_wb_data  (f_wdata),
        .o_data     (f_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] rs_d, rt_d, imm;
        logic [4:0]  rs, rt, rd;
        logic [2:0]  op;
        logic [3:0]  sh;
        logic        src, rw, mr, mw;
        logic        m_we;
        logic [4:0]  m_rd;
        logic [31:0] m_res;
        logic        w_we;
        logic [4:0]  w_rd;
        logic [31:0] w_res;
        logic        e_stall, e_valid, e_rw, e_mr, e_mw;
        logic [31:0] e_a_f, e_a_n, e_b_f, e_b_n, e_sd_f, e_sd_n;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_id(input logic valid, input logic [31:0] rs_d, input logic [31:0] rt_d,
                          input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [2:0] op, input logic [3:0] sh,
                          input logic src, input logic rw, input logic mr, input logic mw);
        bus.id_valid     = valid;
        bus.id_rs_data   = rs_d;
        bus.id_rt_data   = rt_d;
        bus.id_imm       = imm;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rd        = rd;
        bus.id_alu_op    = op;
        bus.id_shamt     = sh;
        bus.id_alu_src   = src;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
    endtask

    task automatic set_wb(input logic m_we, input logic [4:0] m_rd, input logic [31:0] m_res,
                          input logic w_we, input logic [4:0] w_rd, input logic [31:0] w_res);
        bus.mem_reg_write = m_we;
        bus.mem_rd        = m_rd;
        bus.mem_result    = m_res;
        bus.wb_reg_write  = w_we;
        bus.wb_rd         = w_rd;
        bus.wb_result     = w_res;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.flush = 1'b0;
        set_id(1'b1, 32'h1111, 32'h2222, 32'h3333, 5'd1, 5'd2, 5'd3, ALU_ADD, 4'd5,
               1'b1, 1'b1, 1'b1, 1'b1);
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        //                valid rs_d      rt_d      imm       rs    rt     rd     op       sh    src   rw    mr    mw
        //                m_we m_rd m_res       w_we w_rd w_res       stall valid rw mr mw   a_f a_n b_f b_n sd_f sd_n
        vecs[0] = '{1'b1, 32'h1,    32'h2,    32'h0,    5'd5, 5'd6,  5'd7,  ALU_ADD, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd5,  32'h10,    1'b1, 5'd5,  32'h20,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                    32'h10, 32'h1, 32'h2, 32'h2, 32'h2, 32'h2};
        vecs[1] = '{1'b1, 32'h1,    32'h2,    32'h0,    5'd5, 5'd6,  5'd7,  ALU_ADD, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b0, 5'd5,  32'h10,    1'b1, 5'd5,  32'h20,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                    32'h20, 32'h1, 32'h2, 32'h2, 32'h2, 32'h2};
        vecs[2] = '{1'b1, 32'h0,    32'h0,    32'h0,    5'd0, 5'd0,  5'd3,  ALU_OR,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd0,  32'hFFFF,  1'b1, 5'd0,  32'h1234,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 32'h100,  32'h7,    32'h4,    5'd2, 5'd3,  5'd0,  ALU_ADD, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1,
                    1'b1, 5'd3,  32'h55,    1'b1, 5'd3,  32'h66,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                    32'h100, 32'h100, 32'h4, 32'h4, 32'h55, 32'h7};
        vecs[4] = '{1'b1, 32'h9,    32'hA,    32'h0,    5'd9, 5'd10, 5'd12, ALU_SUB, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd11, 32'h111,   1'b1, 5'd10, 32'hAA,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                    32'h9, 32'h9, 32'hAA, 32'hA, 32'hAA, 32'hA};
        vecs[5] = '{1'b0, 32'h3,    32'h4,    32'h0,    5'd1, 5'd2,  5'd13, ALU_SLL, 4'd7, 1'b0, 1'b1, 1'b1, 1'b1,
                    1'b0, 5'd1,  32'h999,   1'b0, 5'd2,  32'h888,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h3, 32'h3, 32'h4, 32'h4, 32'h4, 32'h4};
        vecs[6] = '{1'b1, 32'h1000, 32'h0,    32'h10,   5'd4, 5'd8,  5'd8,  ALU_ADD, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0,
                    1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                    32'h1000, 32'h1000, 32'h10, 32'h10, 32'h0, 32'h0};

        // ---------------- reset state ----------------
        #12;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
        chk("rst_ex_ctl", {29'b0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 32'h0);
        chk("rst_alu_a", bus.ex_alu_a, 32'h0);
        chk("rst_alu_b", bus.ex_alu_b, 32'h0);
        chk("rst_store", bus.ex_store_data, 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table vectors ----------------
        for (int i = 0; i < 7; i++) begin
            set_id(vecs[i].valid, vecs[i].rs_d, vecs[i].rt_d, vecs[i].imm, vecs[i].rs, vecs[i].rt,
                   vecs[i].rd, vecs[i].op, vecs[i].sh, vecs[i].src, vecs[i].rw, vecs[i].mr, vecs[i].mw);
            set_wb(vecs[i].m_we, vecs[i].m_rd, vecs[i].m_res, vecs[i].w_we, vecs[i].w_rd, vecs[i].w_res);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(bus.ex_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_ctl", i), {29'b0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
                {29'b0, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw});
            chk($sformatf("v%0d_op_sh_rd", i), {20'b0, bus.ex_alu_op, bus.ex_shamt, bus.ex_rd},
                {20'b0, vecs[i].op, vecs[i].sh, vecs[i].rd});
            chk($sformatf("v%0d_alu_a", i), bus.ex_alu_a, FWD ? vecs[i].e_a_f : vecs[i].e_a_n);
            chk($sformatf("v%0d_alu_b", i), bus.ex_alu_b, FWD ? vecs[i].e_b_f : vecs[i].e_b_n);
            chk($sformatf("v%0d_store", i), bus.ex_store_data, FWD ? vecs[i].e_sd_f : vecs[i].e_sd_n);
            @(negedge clk);
        end

        // ---------------- load-use (lw rd=8 now in EX) ----------------
        set_id(1'b1, 32'h1, 32'h0, 32'h0, 5'd8, 5'd0, 5'd9, ALU_ADD, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("lu_stall", 32'(bus.stall), FWD ? 32'h1 : 32'h0);
        @(posedge clk);
        #1;
        chk("lu_bubble_valid", 32'(bus.ex_valid), FWD ? 32'h0 : 32'h1);
        chk("lu_bubble_rw", 32'(bus.ex_reg_write), FWD ? 32'h0 : 32'h1);
        chk("lu_stall_drop", 32'(bus.stall), 32'h0);
        @(negedge clk);
        set_wb(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'hABCD);
        @(posedge clk);
        #1;
        chk("lu_add_valid", 32'(bus.ex_valid), 32'h1);
        chk("lu_add_alu_a", bus.ex_alu_a, FWD ? 32'hABCD : 32'h1);
        chk("lu_add_stall", 32'(bus.stall), 32'h0);
        @(negedge clk);

        // ---------------- flush beats load-use ----------------
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 32'h1000, 32'h0, 32'h10, 5'd4, 5'd8, 5'd8, ALU_ADD, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("fl_lw_loaded", 32'(bus.ex_mem_read), 32'h1);
        @(negedge clk);
        set_id(1'b1, 32'h1, 32'h0, 32'h0, 5'd8, 5'd0, 5'd9, ALU_ADD, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("fl_stall", 32'(bus.stall), 32'h0);
        @(posedge clk);
        #1;
        chk("fl_valid", 32'(bus.ex_valid), 32'h0);
        chk("fl_ctl", {29'b0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 32'h0);
        @(negedge clk);
        bus.flush = 1'b0;

        // ---------------- reset in the middle of a stall ----------------
        set_id(1'b1, 32'h1000, 32'h0, 32'h10, 5'd4, 5'd8, 5'd8, ALU_ADD, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_id(1'b1, 32'h77, 32'h66, 32'h0, 5'd8, 5'd8, 5'd9, ALU_ADD, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rs_stall_before", 32'(bus.stall), FWD ? 32'h1 : 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rs_stall_after", 32'(bus.stall), 32'h0);
        chk("rs_valid", 32'(bus.ex_valid), 32'h0);
        chk("rs_mem_read", 32'(bus.ex_mem_read), 32'h0);
        chk("rs_alu_b", bus.ex_alu_b, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- standalone bypass select ----------------
        f_src = 5'd5; f_reg = 32'h1; f_mwe = 1'b1; f_mrd = 5'd5; f_mdata = 32'h10;
        f_wwe = 1'b1; f_wrd = 5'd5; f_wdata = 32'h20;
        #1; chk("fu_mem_prio", f_out, 32'h10);
        f_mwe = 1'b0;
        #1; chk("fu_wb", f_out, 32'h20);
        f_wrd = 5'd6;
        #1; chk("fu_none", f_out, 32'h1);
        f_src = 5'd0; f_reg = 32'h0; f_mwe = 1'b1; f_mrd = 5'd0; f_mdata = 32'hFFFF;
        #1; chk("fu_zero", f_out, 32'h0);
        f_src = 5'd21; f_reg = 32'h5; f_mrd = 5'd5; f_wwe = 1'b1; f_wrd = 5'd21;
        #1; chk("fu_full_index", f_out, 32'h20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core. It registers decoded operands and control from decode and resolves RAW hazards by forwarding from the MEM and WB stages. It presents final operands and control to the ALU, and detects load-use hazards, stalling decode and inserting a bubble. Sits between the decode/register-file stage and the ALU in the EX stage.

## Interface
Parameters:
- DW, 32, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  sign-extended immediate
- id_rs, id_rt, id_rd  in  RW  source and destination indices
- id_alu_op  in  3  ALU op (000 and, 001 or, 010 add, 110 sub, 011 sll)
- id_shamt  in  4  shift amount
- id_alu_src  in  1  1: operand B = immediate
- id_reg_write, id_mem_read, id_mem_write  in  1  control
- flush  in  1  taken branch; kill decode slot
- mem_reg_write, mem_rd, mem_result  in  1/RW/DW  EX/MEM writeback info
- wb_reg_write, wb_rd, wb_result  in  1/RW/DW  MEM/WB writeback info
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  EX slot valid
- ex_alu_a, ex_alu_b  out  DW  ALU operands
- ex_alu_op  out  3; ex_shamt  out  4
- ex_store_data  out  DW  forwarded rt value for stores
- ex_rd  out  RW; ex_reg_write, ex_mem_read, ex_mem_write  out  1

## Operation
- Each rising edge loads one of three values:
  - flush=1: bubble.
  - Else stall=1: bubble.
  - Else: load all id_* fields, and ex_valid <= id_valid.
- Bubble: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write cleared. Data fields don't-care, but cleared to 0 for determinism.
- id_valid=0 loads with ex_reg_write/mem_read/mem_write forced 0.
- Forwarding (combinational, per source, applied to registered rs/rt data):
  - The MEM result is used if mem_reg_write && mem_rd==src && src!=0.
  - Else the WB result is used if wb_reg_write && wb_rd==src && src!=0.
  - Else the registered value is used.
  - MEM has priority over WB.
- ex_alu_a = fwd(rs). ex_alu_b = ex_alu_src ? imm : fwd(rt). ex_store_data = fwd(rt) always.
- Load-use hazard: stall = ex_valid && ex_mem_read && ex_rd!=0 && id_valid && (ex_rd==id_rs || ex_rd==id_rt) && !flush.
- All comparisons use full RW bits. There is no arithmetic in this block.

## Timing
- Reset (async assert, sync release): every registered output is 0. ex_alu_a/b and ex_store_data read 0 while mem/wb_reg_write are 0.
- Latency: one cycle from id_* to ex_* control. Operands reflect forwarded data in the same cycle the mem/wb inputs change.
- Load-use: stall is high for exactly one cycle. The bubble enters EX on that edge, and the held instruction loads on the next edge, receiving load data via WB forwarding.
- flush and hazard in the same cycle: flush wins, stall=0, bubble inserted.
- Reset mid-stall: stall drops immediately (ex_valid=0).

## Configuration
- ID_EX_FORWARD_EN defined: forwarding muxes and load-use stall as above.
- Undefined: ex_alu_a = registered rs data, ex_alu_b / ex_store_data from registered rt/imm. stall tied 0. The mem_*/wb_* inputs are ignored; software must schedule around hazards.

## Structure
- Shared package mips_pkg: DW/RW defaults, the ALU op localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLL), and the register-zero constant.
- One sub-module, forward_unit: takes src index, registered data and the mem/wb triples, and returns the selected value. It is instantiated twice (rs, rt).

## Test plan
- Reset: drive id_* with nonzero values, pulse rst_n low mid-cycle -> all ex_* outputs 0 immediately, stall=0.
- MEM priority: EX add rs=5, rs_data=0x1; mem_rd=5 result=0x10, wb_rd=5 result=0x20, both writes=1 -> ex_alu_a=0x10. Drop mem_reg_write -> 0x20.
- Register zero: rs=0, rs_data=0; mem_rd=0, mem_result=0xFFFF, mem_reg_write=1 -> ex_alu_a=0.
- Load-use: EX lw rd=8 (mem_read=1), ID add rs=8 -> stall=1 for one cycle. Next cycle ex_valid=0 and ex_reg_write=0. The cycle after, the add enters EX with wb_rd=8 wb_result=0xABCD -> ex_alu_a=0xABCD.
- Flush priority: same load-use setup with flush=1 -> stall=0, next cycle ex_valid=0.
- Immediate/store: sw with alu_src=1, imm=0x4, rt=3 forwarded from MEM as 0x55 -> ex_alu_b=0x4, ex_store_data=0x55, ex_mem_write=1.
